pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall/flush controller for a 5-stage core. Handles
//               load-use interlock, taken-branch flush, single-step debug
//               mode, HALT drain sequencing and an enabled-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_mode_step,
    input  logic                  i_step_req,
    input  logic                  i_halt_instr,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_branch_taken,
    output logic                  o_enable,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_id_bubble,
    output logic                  o_if_id_flush,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_cycle_count
);

    // Drain counter must hold DRAIN_CYCLES; keep at least one bit.
    localparam int C_DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        WAIT_STEP = 3'd1,
        STEP_ONE  = 3'd2,
        DRAIN     = 3'd3,
        HALTED    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [C_DRAIN_W-1:0]   r_drain_cnt;
    logic [C_DRAIN_W-1:0]   w_drain_cnt_next;
    logic                   r_step_req_d;
    logic [CNT_W-1:0]       r_cycle_count;

    logic                   w_step_edge;
    logic                   w_hazard;
    logic                   w_active;

    assign w_step_edge = i_step_req & ~r_step_req_d;

    // Load-use interlock: a load into a nonzero register read by ID.
    assign w_hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

    // States in which fresh instructions may flow through IF/ID.
    assign w_active = (r_state == RUN) || (r_state == STEP_ONE);

    // State, drain counter and step-edge history registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= RUN;
            r_drain_cnt  <= '0;
            r_step_req_d <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drain_cnt  <= w_drain_cnt_next;
            r_step_req_d <= i_step_req;
        end
    end

    // Enabled-cycle counter, saturating at all-ones.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cycle_count <= '0;
        end else if (o_enable && (r_cycle_count != {CNT_W{1'b1}})) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    // Next-state logic; a HALT outranks a mode change in the same cycle.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        case (r_state)
            RUN, STEP_ONE: begin
                if (i_halt_instr && !w_hazard) begin
                    w_state_next     = DRAIN;
                    w_drain_cnt_next = C_DRAIN_W'(DRAIN_CYCLES);
                end else if (i_mode_step) begin
                    w_state_next = WAIT_STEP;
                end else begin
                    w_state_next = RUN;
                end
            end
            WAIT_STEP: begin
                if (!i_mode_step) begin
                    w_state_next = RUN;
                end else if (w_step_edge) begin
                    w_state_next = STEP_ONE;
                end
            end
            DRAIN: begin
                if (r_drain_cnt != '0) begin
                    w_drain_cnt_next = r_drain_cnt - 1'b1;
                end
                if (r_drain_cnt <= C_DRAIN_W'(1)) begin
                    w_state_next = HALTED;
                end
            end
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    // Stall/flush outputs decoded from state and current-cycle inputs.
    always_comb begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_id_bubble   = 1'b0;
        o_if_id_flush = 1'b0;
        if (w_active) begin
            if (w_hazard) begin
                o_id_bubble = 1'b1;
            end else begin
                o_pc_write    = 1'b1;
                o_if_id_write = 1'b1;
                o_if_id_flush = i_branch_taken;
            end
        end else if (r_state == DRAIN) begin
            o_id_bubble = 1'b1;
        end
    end

    assign o_enable      = w_active || (r_state == DRAIN);
    assign o_halted      = (r_state == HALTED);
    assign o_cycle_count = r_cycle_count;

endmodule
`default_nettype wire
